// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: turns core load/store requests into aligned memory-bus
// transactions with byte-lane steering, load extension and a bus-wait timeout.
module ysyx_22041211_lsu #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_LEN-1:0]   req_addr,
    input  logic [DATA_LEN-1:0]   req_wdata,
    input  logic [3:0]            req_len,
    input  logic                  req_sign,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_LEN-1:0]   rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_LEN-1:0]   mem_addr,
    output logic                  mem_wen,
    output logic [DATA_LEN-1:0]   mem_wdata,
    output logic [DATA_LEN/8-1:0] mem_wstrb,
    input  logic                  mem_rvalid,
    input  logic [DATA_LEN-1:0]   mem_rdata
);
    localparam int STRB_W = DATA_LEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PAD_W  = 7;
    localparam int CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;

    logic                    r_wen;
    logic [3:0]              r_len;
    logic                    r_sign;
    logic [OFF_W-1:0]        r_off;
    logic [ADDR_LEN-1:0]     r_memAddr;
    logic [DATA_LEN-1:0]     r_memWdata;
    logic [STRB_W-1:0]       r_memWstrb;
    logic [DATA_LEN-1:0]     r_rdata;
    logic                    r_err;
    logic [CNT_W-1:0]        r_cnt;

    logic                    w_accept;
    logic                    w_legal;
    logic [7:0]              w_sizeMask;
    logic [OFF_W-1:0]        w_off;
    logic [STRB_W-1:0]       w_strbShift;
    logic [DATA_LEN-1:0]     w_wdataShift;
    logic [ADDR_LEN-1:0]     w_alignAddr;
    logic [CNT_W-1:0]        w_cntNext;
    logic                    w_expire;
    logic [PAD_W-1:0]        w_pad;
    logic [DATA_LEN-1:0]     w_loadShift;
    logic [DATA_LEN-1:0]     w_loadAlign;
    logic signed [DATA_LEN-1:0] w_loadSigned;
    logic [DATA_LEN-1:0]     w_loadData;

    assign req_ready = (r_state == IDLE) && rst;
    assign w_accept  = req_valid && req_ready;
    assign mem_valid = (r_state == REQ);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign mem_addr  = r_memAddr;
    assign mem_wen   = r_wen;
    assign mem_wdata = r_memWdata;
    assign mem_wstrb = r_memWstrb;

    assign w_off        = req_addr[OFF_W-1:0];
    assign w_alignAddr  = {req_addr[ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}};
    assign w_wdataShift = req_wdata << {w_off, 3'b000};
    assign w_strbShift  = STRB_W'(w_sizeMask) << w_off;

    assign w_cntNext = r_cnt + 1'b1;
    assign w_expire  = (TIMEOUT > 0) && (w_cntNext >= CNT_W'(TIMEOUT));

    // Size decode and natural-alignment check; anything else is rejected locally.
    always_comb begin
        w_legal    = 1'b0;
        w_sizeMask = 8'h00;
        case (req_len)
            4'b0001: begin
                w_legal    = 1'b1;
                w_sizeMask = 8'h01;
            end
            4'b0010: begin
                w_legal    = (req_addr[0] == 1'b0);
                w_sizeMask = 8'h03;
            end
            4'b0100: begin
                w_legal    = (req_addr[1:0] == 2'b00);
                w_sizeMask = 8'h0F;
            end
            4'b1000: begin
                w_legal    = (DATA_LEN == 64) && (req_addr[2:0] == 3'b000);
                w_sizeMask = 8'hFF;
            end
            default: begin
                w_legal    = 1'b0;
                w_sizeMask = 8'h00;
            end
        endcase
    end

    // Extension is done by parking the field at the top of the word and shifting back down.
    always_comb begin
        w_loadShift = mem_rdata >> {r_off, 3'b000};
        w_pad       = '0;
        case (r_len)
            4'b0001: w_pad = PAD_W'(DATA_LEN - 8);
            4'b0010: w_pad = PAD_W'(DATA_LEN - 16);
            4'b0100: w_pad = PAD_W'(DATA_LEN - 32);
            default: w_pad = '0;
        endcase
        w_loadAlign  = w_loadShift << w_pad;
        w_loadSigned = w_loadAlign;
        if (r_sign) begin
            w_loadData = w_loadSigned >>> w_pad;
        end else begin
            w_loadData = w_loadAlign >> w_pad;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A bus handshake or completion always wins over an expiring timeout in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = w_legal ? REQ : RESP;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    w_stateNext = WAIT;
                end else if (w_expire) begin
                    w_stateNext = RESP;
                end
            end
            WAIT: begin
                if (mem_rvalid || w_expire) begin
                    w_stateNext = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen      <= 1'b0;
            r_len      <= 4'b0000;
            r_sign     <= 1'b0;
            r_off      <= '0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWstrb <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_wen      <= req_wen;
                        r_len      <= req_len;
                        r_sign     <= req_sign;
                        r_off      <= w_off;
                        r_memAddr  <= w_alignAddr;
                        r_memWdata <= w_wdataShift;
                        r_memWstrb <= w_strbShift;
                        r_rdata    <= '0;
                        r_err      <= ~w_legal;
                        r_cnt      <= '0;
                    end
                end
                REQ: begin
                    r_cnt <= w_cntNext;
                    if (!mem_ready && w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                WAIT: begin
                    r_cnt <= w_cntNext;
                    if (mem_rvalid) begin
                        r_rdata <= r_wen ? '0 : w_loadData;
                        r_err   <= 1'b0;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Self-checking bench for ysyx_22041211_lsu: directed corner cases plus random
// accesses compared against a byte-level behavioural model of the LSU.
module tb_ysyx_22041211_lsu;
    localparam int DL = 32;
    localparam int AL = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [AL-1:0] req_addr;
    logic [DL-1:0] req_wdata;
    logic [3:0]    req_len;
    logic          req_sign;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DL-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_valid;
    logic          mem_ready;
    logic [AL-1:0] mem_addr;
    logic          mem_wen;
    logic [DL-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_rvalid;
    logic [DL-1:0] mem_rdata;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    ysyx_22041211_lsu #(
        .DATA_LEN(DL),
        .ADDR_LEN(AL),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    // Access size in bytes; 0 marks a size that cannot exist on a 32-bit bus.
    function automatic int sizeOf(input logic [3:0] len);
        case (len)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] expLoad(input logic [31:0] word, input int off,
                                            input int n, input logic sign);
        logic [63:0] v;
        logic [63:0] mask;
        mask = (64'd1 << (8 * n)) - 64'd1;
        v = ({32'd0, word} >> (8 * off)) & mask;
        if (sign && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One full transaction; the memory answers after d1 REQ cycles and d2 WAIT cycles.
    task automatic run_access(input string tag, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] len, input logic sign,
                              input logic [31:0] memWord, input int d1, input int d2,
                              input int rspHold);
        int n, off, lim, done, expEnd, cyc, waitCyc;
        bit legal, expErr, hs;
        logic [31:0] expRdata, expWdata, expAddr;
        logic [3:0]  expStrb;
        logic [63:0] wide;

        n = sizeOf(len);
        off = int'(addr[1:0]);
        legal = 1'b0;
        if (n != 0) legal = ((off % n) == 0);
        done = d1 + d2 + 2;
        if (!legal) expEnd = 0;
        else if (d1 + 1 > TO) expEnd = TO;
        else begin
            lim = (TO > d1 + 2) ? TO : d1 + 2;
            expEnd = (done > lim) ? lim : done;
        end
        expErr = !legal || (expEnd != done);
        expRdata = (expErr || wen) ? 32'd0 : expLoad(memWord, off, n, sign);
        expAddr = addr & ~32'd3;
        wide = {32'd0, wdata} << (8 * off);
        expWdata = wide[31:0];
        expStrb = 4'(((1 << n) - 1) << off);

        nTests++;
        if (req_ready !== 1'b1) begin
            nFail++;
            $display("FAIL %s req_ready before request: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_len   = len;
        req_sign  = sign;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wen   = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_len   = 4'($urandom);
        req_sign  = 1'($urandom);

        cyc = 0;
        waitCyc = 0;
        hs = 1'b0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            cyc++;
            nTests++;
            if (req_ready !== 1'b0) begin
                nFail++;
                $display("FAIL %s req_ready busy: got %b want 0", tag, req_ready);
            end
            if (!hs) begin
                nTests++;
                if (mem_valid !== 1'b1 || mem_addr !== expAddr || mem_wen !== wen ||
                    (wen && (mem_wdata !== expWdata || mem_wstrb !== expStrb))) begin
                    nFail++;
                    $display("FAIL %s mem request cyc %0d: got v=%b a=%h we=%b d=%h s=%b want v=1 a=%h we=%b d=%h s=%b",
                             tag, cyc, mem_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
                             expAddr, wen, expWdata, expStrb);
                end
                mem_ready  = (cyc == d1 + 1);
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
            end else begin
                waitCyc++;
                nTests++;
                if (mem_valid !== 1'b0) begin
                    nFail++;
                    $display("FAIL %s mem_valid in wait: got %b want 0", tag, mem_valid);
                end
                mem_rvalid = (waitCyc == d2 + 1);
                mem_rdata  = mem_rvalid ? memWord : $urandom;
            end
            @(posedge clk); #1;
            if (mem_ready) hs = 1'b1;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
        end

        nTests++;
        if (rsp_valid !== 1'b1 || cyc != expEnd) begin
            nFail++;
            $display("FAIL %s response latency: got valid=%b after %0d cycles want valid=1 after %0d",
                     tag, rsp_valid, cyc + 1, expEnd + 1);
        end
        nTests++;
        if (rsp_err !== expErr || rsp_rdata !== expRdata) begin
            nFail++;
            $display("FAIL %s response: got err=%b data=%h want err=%b data=%h",
                     tag, rsp_err, rsp_rdata, expErr, expRdata);
        end
        nTests++;
        if (mem_valid !== 1'b0) begin
            nFail++;
            $display("FAIL %s mem_valid in resp: got %b want 0", tag, mem_valid);
        end

        for (int i = 0; i < rspHold; i++) begin
            rsp_ready  = 1'b0;
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            nTests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== expRdata || rsp_err !== expErr) begin
                nFail++;
                $display("FAIL %s resp hold %0d: got v=%b err=%b data=%h want v=1 err=%b data=%h",
                         tag, i, rsp_valid, rsp_err, rsp_rdata, expErr, expRdata);
            end
        end

        // A request offered during the closing handshake must not be taken.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_len   = 4'b0001;
        nTests++;
        if (req_ready !== 1'b0) begin
            nFail++;
            $display("FAIL %s req_ready during resp handshake: got %b want 0", tag, req_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        nTests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            nFail++;
            $display("FAIL %s after handshake: got rsp_valid=%b req_ready=%b want 0 1",
                     tag, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            nTests++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
                mem_valid !== 1'b0 || mem_wen !== 1'b0) begin
                nFail++;
                $display("FAIL reset controls %0d: got rr=%b rv=%b re=%b mv=%b mw=%b want all 0",
                         i, req_ready, rsp_valid, rsp_err, mem_valid, mem_wen);
            end
            nTests++;
            if (rsp_rdata !== 32'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0 ||
                mem_addr !== 32'd0) begin
                nFail++;
                $display("FAIL reset data %0d: got rd=%h wd=%h ws=%b a=%h want all 0",
                         i, rsp_rdata, mem_wdata, mem_wstrb, mem_addr);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        nTests++;
        if (req_ready !== 1'b1) begin
            nFail++;
            $display("FAIL reset release req_ready: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_access("load_byte_signed", 1'b0, 32'h8000_0003, 32'h0, 4'b0001, 1'b1,
                   32'h80FF_FFFF, 0, 0, 0);
        run_access("store_half", 1'b1, 32'h8000_0002, 32'h0000_1234, 4'b0010, 1'b0,
                   32'hDEAD_BEEF, 0, 0, 1);
        run_access("load_half_zero", 1'b0, 32'h8000_0002, 32'h0, 4'b0010, 1'b0,
                   32'h9ABC_1234, 1, 1, 0);
        run_access("load_word", 1'b0, 32'h8000_0008, 32'h0, 4'b0100, 1'b1,
                   32'h8765_4321, 0, 1, 2);
    endtask

    task automatic test_illegal();
        run_access("word_misaligned", 1'b0, 32'h8000_0001, 32'h0, 4'b0100, 1'b0, 32'h0, 0, 0, 0);
        run_access("half_odd", 1'b1, 32'h8000_0003, 32'hFFFF, 4'b0010, 1'b0, 32'h0, 0, 0, 1);
        run_access("double_on_32", 1'b0, 32'h8000_0000, 32'h0, 4'b1000, 1'b0, 32'h0, 0, 0, 0);
        run_access("len_zero", 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 1'b0, 32'h0, 0, 0, 0);
        run_access("len_two_hot", 1'b1, 32'h8000_0004, 32'h55, 4'b0110, 1'b0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        run_access("timeout_no_ready", 1'b0, 32'h8000_0040, 32'h0, 4'b0100, 1'b0,
                   32'h1111_2222, 100, 0, 1);
        run_access("timeout_no_rvalid", 1'b1, 32'h8000_0041, 32'hAB, 4'b0001, 1'b0,
                   32'h0, 0, 100, 0);
        run_access("late_ready_in_time", 1'b0, 32'h8000_0042, 32'h0, 4'b0001, 1'b1,
                   32'h00FE_0000, 3, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  lens [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        logic [3:0]  len;
        logic [31:0] addr;
        int          n, d1, d2, pick;
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 9);
            len = (pick < 3) ? lens[0] : (pick < 5) ? lens[1] : (pick < 8) ? lens[2] :
                  (pick < 9) ? lens[3] : 4'($urandom);
            n = sizeOf(len);
            addr = $urandom;
            if (n != 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
            d1 = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 6) : $urandom_range(0, 1);
            d2 = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 5) : $urandom_range(0, 1);
            run_access("random", 1'($urandom), addr, $urandom, len, 1'($urandom),
                       $urandom, d1, d2, $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_abort();
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h8000_0010;
        req_len   = 4'b0100;
        req_sign  = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nTests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin
                nFail++;
                $display("FAIL abort_resp hold %0d: got v=%b data=%h want v=1 data=cafef00d",
                         i, rsp_valid, rsp_rdata);
            end
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        nTests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            nFail++;
            $display("FAIL abort_resp immediate reset: got v=%b rr=%b data=%h err=%b want 0 0 0 0",
                     rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nTests++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0) begin
                nFail++;
                $display("FAIL abort_resp late rvalid %0d: got rv=%b rr=%b mv=%b want 0 1 0",
                         i, rsp_valid, req_ready, mem_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_abort();
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h8000_0020;
        req_len   = 4'b0001;
        req_sign  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        nTests++;
        if (mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            nFail++;
            $display("FAIL abort_wait state: got mv=%b rv=%b want 0 0", mem_valid, rsp_valid);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00FF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nTests++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                nFail++;
                $display("FAIL abort_wait late rvalid %0d: got rv=%b rr=%b want 0 1",
                         i, rsp_valid, req_ready);
            end
            @(posedge clk); #1;
        end
        run_access("after_abort", 1'b0, 32'h8000_0021, 32'h0, 4'b0001, 1'b1,
                   32'h0000_8000, 0, 0, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_len    = 4'b0000;
        req_sign   = 1'b0;
        rsp_ready  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        test_reset();
        test_directed();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        test_wait_abort();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got stuck want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
